// File: rtl/montgomery_mult_param.sv
// Montgomery modular multiplier: result = A*B*2^-WIDTH mod M (odd M), BPC multiplier bits per cycle.
// Latency: done in cycle t+WIDTH/BPC+2 for odd M, t+1 for even M (start sampled at edge t).
// Backpressure: none; start is accepted only in IDLE, and start while busy is silently ignored.
//
// Ports:
//   clk      rising-edge clock
//   reset    synchronous active-high reset; an operation in flight is aborted without done
//   start    single-cycle request, sampled only in IDLE
//   in_a     multiplicand A (A < M), captured on accepted start
//   in_b     multiplier B (B < M), captured on accepted start
//   in_m     modulus M (odd), captured on accepted start
//   busy     high from the cycle after an accepted start through the done cycle
//   result   product, valid from the done cycle and held until overwritten by the next run
//   done     one-cycle completion pulse
//   err      valid with done: 1 means the modulus was even and result is forced to 0

module montgomery_mult_param #(
   parameter int WIDTH = 512,
   parameter int BPC   = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [WIDTH-1:0] in_m,
   output logic             busy,
   output logic [WIDTH-1:0] result,
   output logic             done,
   output logic             err
);

   // Number of ITER cycles and the counter that walks through them.
   localparam int N     = WIDTH / BPC;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   // Elaboration-time guard on parameter legality.
   if (!(BPC == 1 || BPC == 2 || BPC == 4)) begin : g_bad_bpc
      $error("montgomery_mult_param: BPC must be 1, 2 or 4");
   end
   if ((WIDTH < 8) || ((WIDTH % BPC) != 0)) begin : g_bad_width
      $error("montgomery_mult_param: WIDTH must be >= 8 and a multiple of BPC");
   end

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ITER = 2'd1,
      S_SUB  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t state_q;
   state_t state_d;

   // Captured operands. a_q is consumed LSB-first: it shifts right by BPC
   // every ITER cycle, so bits [BPC-1:0] always hold A[BPC*k +: BPC].
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] m_q;

   // Montgomery accumulator; stays below 2M, hence one extra bit.
   logic [WIDTH:0]   c_q;
   logic [CNT_W-1:0] cnt_q;

   logic             busy_q;
   logic             done_q;
   logic             err_q;
   logic [WIDTH-1:0] result_q;

   logic             busy_d;
   logic             done_d;

   // Combinational datapath
   logic [WIDTH+1:0] step_t;
   logic [WIDTH:0]   c_acc;
   logic [WIDTH:0]   c_step;
   logic             sub_neg;
   logic [WIDTH-1:0] sub_lo;

   // --------------------------------------------------------------------
   // FSM: state register
   // --------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // --------------------------------------------------------------------
   // FSM: next-state logic
   // --------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               // Even modulus has no inverse of 2; report it straight away.
               state_d = in_m[0] ? S_ITER : S_DONE;
            end
         end
         S_ITER: begin
            if (cnt_q == CNT_LAST) begin
               state_d = S_SUB;
            end
         end
         S_SUB:   state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // --------------------------------------------------------------------
   // FSM: output decode. Decoded from the next state and registered below
   // so busy/done come straight from flops.
   // --------------------------------------------------------------------
   always_comb begin
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   // --------------------------------------------------------------------
   // BPC unrolled radix-2 Montgomery steps for one ITER cycle.
   // t = C + a_j*B < 3M and t + q*M < 4M both fit in WIDTH+2 bits; the
   // halved value is < 2M and fits back into WIDTH+1 bits.
   // --------------------------------------------------------------------
   always_comb begin
      step_t = '0;
      c_acc  = c_q;
      for (int j = 0; j < BPC; j++) begin
         step_t = {1'b0, c_acc} + (a_q[j] ? {2'b00, b_q} : {(WIDTH+2){1'b0}});
         if (step_t[0]) begin
            step_t = step_t + {2'b00, m_q};
         end
         c_acc = step_t[WIDTH+1:1];
      end
      c_step = c_acc;
   end

   // --------------------------------------------------------------------
   // Final conditional subtraction. The sign of C - M is taken from a
   // magnitude compare; when C >= M the difference is below M < 2^WIDTH,
   // so the low WIDTH bits of the wrap-around subtraction are exact.
   // --------------------------------------------------------------------
   always_comb begin
      sub_neg = (c_q < {1'b0, m_q});
      sub_lo  = c_q[WIDTH-1:0] - m_q;
   end

   // --------------------------------------------------------------------
   // Datapath and output registers
   // --------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         a_q      <= '0;
         b_q      <= '0;
         m_q      <= '0;
         c_q      <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         result_q <= '0;
      end else begin
         busy_q <= busy_d;
         done_q <= done_d;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  a_q   <= in_a;
                  b_q   <= in_b;
                  m_q   <= in_m;
                  c_q   <= '0;
                  cnt_q <= '0;
                  if (!in_m[0]) begin
                     result_q <= '0;
                     err_q    <= 1'b1;
                  end
               end
            end
            S_ITER: begin
               c_q   <= c_step;
               a_q   <= a_q >> BPC;
               cnt_q <= cnt_q + CNT_ONE;
            end
            S_SUB: begin
               result_q <= sub_neg ? c_q[WIDTH-1:0] : sub_lo;
               err_q    <= 1'b0;
            end
            default: begin
               // DONE: hold everything; the outputs already carry the answer.
            end
         endcase
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign err    = err_q;
   assign result = result_q;

endmodule
